ctrl_src_bank: RTL and testbench

- Clocked, multi-channel digital controlled source: each sample on a channel is scaled by a per-channel programmable gain, rounded, saturated and optionally slew-limited.
- Generalises the fixed single-gain VCVS/VCCS mapping to NCH channels with run-time gains, fixed-point arithmetic and streaming valid/ready flow control.
- Sits between a sample producer (stimulus/ADC model) and a consumer (DAC model/sink) in mixed-signal test harnesses.

---
 rtl/ctrl_src_bank.sv | 169 ++++++++++++++++
 tb/tb_ctrl_src_bank.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_src_bank.sv
// ctrl_src_bank: NCH-channel programmable-gain source. Each sample is scaled by
// its channel gain, rounded half up, saturated to DW bits, and passed through a
// two-stage valid/ready pipeline (latency 2, one sample per clock).
// Build macro SLEW_LIMIT_EN adds per-channel output slew limiting by SLEW.
module ctrl_src_bank #(
    parameter int NCH   = 4,
    parameter int DW    = 16,
    parameter int GW    = 16,
    parameter int GFRAC = 8,
    parameter int SLEW  = 256,
    parameter int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [CW-1:0]        cfg_ch,
    input  logic signed [GW-1:0] cfg_gain,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CW-1:0]        in_ch,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_ch,
    output logic signed [DW-1:0] out_data,
    output logic                 out_sat
);
    localparam int PW = DW + GW + 1;
    localparam logic signed [PW-1:0] RND  = PW'(2 ** (GFRAC - 1));
    localparam logic signed [PW-1:0] RMAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW-1:0] RMIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [GW-1:0] GONE = GW'(2 ** GFRAC);

    logic signed [GW-1:0] gain_q [NCH];
    logic signed [GW-1:0] gain_d [NCH];

    logic                 s1_valid_q, s1_valid_d;
    logic [CW-1:0]        s1_ch_q, s1_ch_d;
    logic signed [DW-1:0] s1_data_q, s1_data_d;
    logic                 s1_sat_q, s1_sat_d;

    logic                 out_valid_q, out_valid_d;
    logic [CW-1:0]        out_ch_q, out_ch_d;
    logic signed [DW-1:0] out_data_q, out_data_d;
    logic                 out_sat_q, out_sat_d;

    logic                 adv, accept, in_ch_ok, cfg_ch_ok, take;
    logic signed [GW-1:0] gain_sel;
    logic signed [PW-1:0] in_ext, gain_ext, prod, rnd_sum, rshift;
    logic signed [DW-1:0] s2_val;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign accept    = in_valid && adv;
    assign in_ch_ok  = int'(in_ch) < NCH;
    assign cfg_ch_ok = int'(cfg_ch) < NCH;
    assign take      = accept && in_ch_ok;

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    // Gain table write port; stage 1 reads the pre-edge value.
    always_comb begin
        gain_d = gain_q;
        if (cfg_we && cfg_ch_ok) gain_d[cfg_ch] = cfg_gain;
    end

    // Stage 1: multiply, round half up, saturate; out-of-range channels are dropped.
    always_comb begin
        gain_sel   = in_ch_ok ? gain_q[in_ch] : '0;
        in_ext     = PW'(in_data);
        gain_ext   = PW'(gain_sel);
        prod       = in_ext * gain_ext;
        rnd_sum    = prod + RND;
        rshift     = rnd_sum >>> GFRAC;
        s1_valid_d = s1_valid_q;
        s1_ch_d    = s1_ch_q;
        s1_data_d  = s1_data_q;
        s1_sat_d   = s1_sat_q;
        if (adv) begin
            s1_valid_d = take;
            if (take) begin
                s1_ch_d = in_ch;
                if (rshift > RMAX) begin
                    s1_data_d = RMAX[DW-1:0];
                    s1_sat_d  = 1'b1;
                end else if (rshift < RMIN) begin
                    s1_data_d = RMIN[DW-1:0];
                    s1_sat_d  = 1'b1;
                end else begin
                    s1_data_d = rshift[DW-1:0];
                    s1_sat_d  = 1'b0;
                end
            end
        end
    end

`ifdef SLEW_LIMIT_EN
    localparam int DW1 = DW + 1;
    localparam logic signed [DW:0] SLEW_V = DW1'(SLEW);

    logic signed [DW-1:0] hist_q [NCH];
    logic signed [DW-1:0] hist_d [NCH];
    logic signed [DW:0]   last_ext, diff, lim;

    // Slew clamp against the channel history; history follows each delivered load.
    always_comb begin
        last_ext = DW1'(hist_q[s1_ch_q]);
        diff     = DW1'(s1_data_q) - last_ext;
        if (diff > SLEW_V)       lim = last_ext + SLEW_V;
        else if (diff < -SLEW_V) lim = last_ext - SLEW_V;
        else                     lim = DW1'(s1_data_q);
        s2_val = lim[DW-1:0];
        hist_d = hist_q;
        if (adv && s1_valid_q) hist_d[s1_ch_q] = s2_val;
    end

    // Slew history registers.
    always_ff @(posedge clk) begin
        if (rst) hist_q <= '{default: '0};
        else     hist_q <= hist_d;
    end
`else
    assign s2_val = s1_data_q;
`endif

    // Stage 2: output register; data fields only reload when a sample moves in.
    always_comb begin
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_ch_d   = s1_ch_q;
                out_data_d = s2_val;
                out_sat_d  = s1_sat_q;
            end
        end
    end

    // Pipeline and gain-table state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            gain_q      <= '{default: GONE};
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            s1_data_q   <= '0;
            s1_sat_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            gain_q      <= gain_d;
            s1_valid_q  <= s1_valid_d;
            s1_ch_q     <= s1_ch_d;
            s1_data_q   <= s1_data_d;
            s1_sat_q    <= s1_sat_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end
endmodule

// File: tb/tb_ctrl_src_bank.sv
// Bench for ctrl_src_bank: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a two-slot behavioural model.
module tb_ctrl_src_bank;
    localparam int NCH   = 4;
    localparam int DW    = 16;
    localparam int GW    = 16;
    localparam int GFRAC = 8;
    localparam int SLEW  = 256;
    localparam int CW    = 2;

    logic                 clk, rst, cfg_we, in_valid, in_ready, out_valid, out_ready, out_sat;
    logic [CW-1:0]        cfg_ch, in_ch, out_ch;
    logic signed [GW-1:0] cfg_gain;
    logic signed [DW-1:0] in_data, out_data;

    ctrl_src_bank #(.NCH(NCH), .DW(DW), .GW(GW), .GFRAC(GFRAC), .SLEW(SLEW)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_gain(cfg_gain),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_data(out_data), .out_sat(out_sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass = 0;
    int n_total = 0;

    typedef struct { bit v; int ch; int val; bit sat; } item_t;

    item_t m1, m2, nx;
    int    m_gain [NCH];
    int    m_hist [NCH];
    bit    m_adv;
    bit    mdl_live = 0;
    item_t got_q [$];

    task automatic chk(input string nm, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    // Gain, round half up, clamp to the signed DW range.
    function automatic void mdl_stage1(input int ch, input int d, output int val, output bit sat);
        longint p, r;
        p = longint'(d) * longint'(m_gain[ch]);
        r = (p + (longint'(1) <<< (GFRAC - 1))) >>> GFRAC;
        sat = 1'b1;
        if (r > 32767)       val = 32767;
        else if (r < -32768) val = -32768;
        else begin
            val = int'(r);
            sat = 1'b0;
        end
    endfunction

    function automatic int mdl_slew(input int ch, input int v);
`ifdef SLEW_LIMIT_EN
        int d, o;
        d = v - m_hist[ch];
        if (d > SLEW)       o = m_hist[ch] + SLEW;
        else if (d < -SLEW) o = m_hist[ch] - SLEW;
        else                o = v;
        m_hist[ch] = o;
        return o;
`else
        return v + 0 * ch;
`endif
    endfunction

    // Reference model: two pipeline slots advancing when the output slot is free or taken.
    always @(posedge clk) begin
        if (rst) begin
            m1 = '{0, 0, 0, 0};
            m2 = '{0, 0, 0, 0};
            for (int i = 0; i < NCH; i++) begin
                m_gain[i] = 1 << GFRAC;
                m_hist[i] = 0;
            end
            mdl_live = 1;
        end else begin
            m_adv = !m2.v || out_ready;
            nx = '{0, 0, 0, 0};
            if (in_valid && m_adv && int'(in_ch) < NCH) begin
                nx.v  = 1;
                nx.ch = int'(in_ch);
                mdl_stage1(nx.ch, int'(in_data), nx.val, nx.sat);
            end
            if (m_adv) begin
                if (m1.v) begin
                    m2 = m1;
                    m2.val = mdl_slew(m1.ch, m1.val);
                end else begin
                    m2.v = 0;
                end
                m1 = nx;
            end
            if (cfg_we && int'(cfg_ch) < NCH) m_gain[cfg_ch] = int'(cfg_gain);
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (mdl_live) begin
            chk("in_ready", in_ready, (!m2.v || out_ready));
            chk("out_valid", out_valid, m2.v);
            if (m2.v) begin
                chk("out_ch", out_ch, m2.ch);
                chk("out_data", out_data, m2.val);
                chk("out_sat", out_sat, m2.sat);
            end
        end
    end

    // Record every delivered sample for the literal checks.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1)
            got_q.push_back('{1, int'(out_ch), int'(out_data), out_sat});
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        @(posedge clk); #1;
        got_q.delete();
    endtask

    task automatic cfg(input int ch, input int g);
        cfg_we = 1'b1;
        cfg_ch = CW'(ch);
        cfg_gain = GW'(g);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic send(input int ch, input int data);
        bit r;
        int k;
        in_valid = 1'b1;
        in_ch = CW'(ch);
        in_data = DW'(data);
        k = 0;
        r = 0;
        while (!r && k < 30) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk); #1;
            k++;
        end
        if (!r) begin
            n_total++;
            $display("FAIL send_timeout: ch %0d data %0d not accepted within 30 cycles", ch, data);
        end
        in_valid = 1'b0;
    endtask

    task automatic check_lit(input string nm, input int ch, input int data, input bit sat);
        int k;
        item_t it;
        k = 0;
        while (got_q.size() == 0 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (got_q.size() == 0) begin
            n_total++;
            $display("FAIL %s: no output within 40 cycles, required data %0d", nm, data);
        end else begin
            it = got_q.pop_front();
            chk({nm, "_ch"}, it.ch, ch);
            chk({nm, "_data"}, it.val, data);
            chk({nm, "_sat"}, it.sat, sat);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_gain = '0;
        in_valid = 1'b0; in_ch = '0; in_data = '0; out_ready = 1'b1;

        // Defaults and two-clock latency.
        do_reset();
        send(0, 100);
        @(negedge clk);
        chk("lat_edge1_valid", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_edge2_valid", out_valid, 1);
        @(posedge clk); #1;
        check_lit("basic", 0, 100, 1'b0);

        // Saturation.
        cfg(1, 512);
        send(1, 20000);
`ifdef SLEW_LIMIT_EN
        check_lit("sat", 1, 256, 1'b1);
`else
        check_lit("sat", 1, 32767, 1'b1);
`endif

        // Slew ramp with an interleaved channel.
        do_reset();
        cfg(2, 256);
        send(2, 1000); send(2, 1000); send(2, 1000); send(3, -50); send(2, 1000);
`ifdef SLEW_LIMIT_EN
        check_lit("ramp0", 2, 256, 1'b0);
        check_lit("ramp1", 2, 512, 1'b0);
        check_lit("ramp2", 2, 768, 1'b0);
        check_lit("ramp_ch3", 3, -50, 1'b0);
        check_lit("ramp3", 2, 1024, 1'b0);
`else
        check_lit("ramp0", 2, 1000, 1'b0);
        check_lit("ramp1", 2, 1000, 1'b0);
        check_lit("ramp2", 2, 1000, 1'b0);
        check_lit("ramp_ch3", 3, -50, 1'b0);
        check_lit("ramp3", 2, 1000, 1'b0);
`endif

        // Rounding half up at gain 0.5.
        do_reset();
        cfg(0, 128);
        send(0, 3); send(0, -3); send(0, 1);
        check_lit("round_p3", 0, 2, 1'b0);
        check_lit("round_m3", 0, -1, 1'b0);
        check_lit("round_p1", 0, 1, 1'b0);

        // Backpressure mid-stream.
        do_reset();
        fork
            begin
                for (int i = 1; i <= 10; i++) send(0, i);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_valid", out_valid, 1);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        for (int i = 1; i <= 10; i++) check_lit("bp", 0, i, 1'b0);

        // Reset with both stages full.
        do_reset();
        cfg(1, 1024);
        send(0, 100); send(0, 200);
        rst = 1'b1;
        @(negedge clk);
        chk("prerst_out_valid", out_valid, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        @(posedge clk); #1;
        got_q.delete();
        send(1, 300);
`ifdef SLEW_LIMIT_EN
        check_lit("after_rst", 1, 256, 1'b0);
`else
        check_lit("after_rst", 1, 300, 1'b0);
`endif

        // Gain write on the same edge as an accept.
        do_reset();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_gain = 16'sd512;
        send(0, 10);
        cfg_we = 1'b0;
        send(0, 10);
        check_lit("coll_old", 0, 10, 1'b0);
        check_lit("coll_new", 0, 20, 1'b0);

        // Randomized traffic, gains, backpressure and occasional reset.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ch     = CW'($urandom_range(0, NCH - 1));
            in_data   = ($urandom_range(0, 1) == 1) ? DW'($urandom) : DW'($urandom_range(0, 2000) - 1000);
            out_ready = ($urandom_range(0, 3) != 0);
            cfg_we    = ($urandom_range(0, 9) == 0);
            cfg_ch    = CW'($urandom_range(0, NCH - 1));
            cfg_gain  = ($urandom_range(0, 1) == 1) ? GW'($urandom) : GW'($urandom_range(0, 1024) - 512);
            @(posedge clk); #1;
        end
        rst = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        got_q.delete();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
